// File: rtl/cmd_engine.sv
// Host command engine: byte-stream commands drive CPU buses, control word and clocks.
// Optional CMD_ENGINE_ACK_EN: '.' ack after non-reply commands, '?' for unknown bytes.
module cmd_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int CW_W = 32,
  parameter int FLAG_W = 4,
  parameter logic [CW_W-1:0] DEFAULT_CW = '0,
  parameter int PULSE_CYC = 1,
  parameter int RST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_oe,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [CW_W-1:0]   control_word,
  output logic              cpu_clk,
  output logic              cpu_iclk,
  output logic              cpu_rst,
  output logic              halted
);

`ifdef CMD_ENGINE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  localparam int NB_D = (DATA_W + 7) / 8;
  localparam int NB_A = (ADDR_W + 7) / 8;
  localparam int NB_C = (CW_W + 7) / 8;
  localparam int NB_M = (NB_C > NB_A) ? ((NB_C > NB_D) ? NB_C : NB_D)
                                      : ((NB_A > NB_D) ? NB_A : NB_D);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARG   = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_CLKH  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_ICLKH = 3'd6;
  localparam logic [2:0] S_HALT  = 3'd7;

  // reply strings stored byte-reversed so byte 0 goes out first
  localparam logic [71:0] IDENT = 72'("MVgolireV");
  localparam logic [71:0] BRK   = 72'("KRB#");

  logic [2:0]        state;
  logic [7:0]        cmd_q;
  logic [8*NB_M-1:0] arg_q;
  logic [3:0]        arg_cnt;
  logic [2:0]        arg_idx;
  logic [71:0]       txbuf;
  logic [3:0]        tx_len;
  logic [3:0]        tx_idx;
  logic [31:0]       pcnt;
  logic [31:0]       rst_cnt;
  logic              unused_arg;

  function automatic logic [3:0] nb_of(input logic [7:0] c);
    if (c == "A") return 4'(NB_A);
    else if (c == "B") return 4'(NB_D);
    else if (c == "O" || c == "M") return 4'(NB_C);
    else return 4'd0;
  endfunction

  assign rx_ready = (state == S_IDLE) || (state == S_ARG);
  assign tx_valid = (state == S_SEND);
  assign tx_data  = txbuf[{tx_idx, 3'b000} +: 8];
  assign cpu_clk  = (state == S_CLKH);
  assign cpu_iclk = (state == S_ICLKH);
  assign halted   = (state == S_HALT);
  assign cpu_rst  = (rst_cnt != 32'd0);
  assign unused_arg = ^arg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cmd_q        <= '0;
      arg_q        <= '0;
      arg_cnt      <= '0;
      arg_idx      <= '0;
      txbuf        <= '0;
      tx_len       <= '0;
      tx_idx       <= '0;
      pcnt         <= '0;
      rst_cnt      <= 32'(RST_CYC);
      bus_out      <= '0;
      bus_oe       <= 1'b0;
      addr_out     <= '0;
      addr_oe      <= 1'b0;
      control_word <= DEFAULT_CW;
    end else begin
      if (rst_cnt != 32'd0) rst_cnt <= rst_cnt - 32'd1;
      unique case (state)
        S_IDLE: if (rx_valid) begin
          cmd_q   <= rx_data;
          arg_q   <= '0;
          arg_idx <= '0;
          arg_cnt <= nb_of(rx_data);
          if (rx_data == "O") begin
            bus_oe  <= 1'b0;
            addr_oe <= 1'b0;
          end
          state <= (nb_of(rx_data) != 4'd0) ? S_ARG : S_EXEC;
        end
        S_ARG: if (rx_valid) begin
          arg_q[{arg_idx, 3'b000} +: 8] <= rx_data;
          arg_idx <= arg_idx + 3'd1;
          arg_cnt <= arg_cnt - 4'd1;
          if (arg_cnt == 4'd1) state <= S_EXEC;
        end
        S_EXEC: begin
          tx_idx <= '0;
          tx_len <= 4'd1;
          txbuf  <= 72'(".");
          state  <= ACK ? S_SEND : S_IDLE;
          unique case (1'b1)
            cmd_q == "I": begin
              txbuf  <= IDENT;
              tx_len <= 4'd9;
              state  <= S_SEND;
            end
            cmd_q == "R": begin
              txbuf  <= BRK;
              tx_len <= 4'd4;
              state  <= S_SEND;
            end
            cmd_q == "a": begin
              txbuf  <= 72'(addr_in);
              tx_len <= 4'(NB_A);
              state  <= S_SEND;
            end
            cmd_q == "b": begin
              txbuf  <= 72'(bus_in);
              tx_len <= 4'(NB_D);
              state  <= S_SEND;
            end
            cmd_q == "s": begin
              txbuf <= 72'(flags_in);
              state <= S_SEND;
            end
            cmd_q == "r": begin
              txbuf <= '0;
              state <= S_SEND;
            end
            cmd_q == "A": begin
              addr_out <= arg_q[ADDR_W-1:0];
              addr_oe  <= 1'b1;
            end
            cmd_q == "B": begin
              bus_out <= arg_q[DATA_W-1:0];
              bus_oe  <= 1'b1;
            end
            cmd_q == "f": begin
              bus_oe  <= 1'b0;
              addr_oe <= 1'b0;
            end
            cmd_q == "O" || cmd_q == "M":
              control_word <= arg_q[CW_W-1:0];
            cmd_q == "c" || cmd_q == "T": begin
              pcnt  <= 32'(PULSE_CYC - 1);
              state <= S_CLKH;
            end
            cmd_q == "C": begin
              pcnt  <= 32'(PULSE_CYC - 1);
              state <= S_ICLKH;
            end
            cmd_q == "Q": state <= S_HALT;
            cmd_q == "N" || cmd_q == 8'hFF: state <= S_IDLE;
            default: txbuf <= 72'("?");
          endcase
        end
        S_SEND: if (tx_ready) begin
          if (tx_idx == tx_len - 4'd1) state <= S_IDLE;
          else tx_idx <= tx_idx + 4'd1;
        end
        S_CLKH: begin
          if (pcnt != 32'd0) pcnt <= pcnt - 32'd1;
          else if (cmd_q == "T") begin
            pcnt  <= 32'(PULSE_CYC - 1);
            state <= S_GAP;
          end else state <= ACK ? S_SEND : S_IDLE;
        end
        S_GAP: begin
          if (pcnt != 32'd0) pcnt <= pcnt - 32'd1;
          else begin
            pcnt  <= 32'(PULSE_CYC - 1);
            state <= S_ICLKH;
          end
        end
        S_ICLKH: begin
          if (pcnt != 32'd0) pcnt <= pcnt - 32'd1;
          else state <= ACK ? S_SEND : S_IDLE;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_engine.sv
// Directed bench for cmd_engine: bus/addr forcing, reads, control word,
// clock pulses, reply flow control, halt and async reset.
module tb_cmd_engine;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int CW_W = 32;
  localparam int FLAG_W = 4;
  localparam logic [31:0] DCW = 32'hA5A5_0F0F;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [DATA_W-1:0] bus_in = '0;
  logic [DATA_W-1:0] bus_out;
  logic bus_oe;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [ADDR_W-1:0] addr_out;
  logic addr_oe;
  logic [FLAG_W-1:0] flags_in = '0;
  logic [CW_W-1:0] control_word;
  logic cpu_clk, cpu_iclk, cpu_rst, halted;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cmd_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CW_W(CW_W), .FLAG_W(FLAG_W),
    .DEFAULT_CW(DCW), .PULSE_CYC(2), .RST_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .addr_in(addr_in), .addr_out(addr_out), .addr_oe(addr_oe),
    .flags_in(flags_in), .control_word(control_word),
    .cpu_clk(cpu_clk), .cpu_iclk(cpu_iclk), .cpu_rst(cpu_rst),
    .halted(halted)
  );

  task automatic check(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_timeout", rx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, tx_valid, 1);
    check(tag, tx_data, exp);
    tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] got[$];
    logic prev_hold;
    logic [7:0] prev_d;
    string ident;
    logic [6:0] t_clk;
    logic [6:0] t_iclk;
    logic [6:0] t_rdy;

    @(negedge clk);
    check("rst_cw", control_word, DCW);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_oe", {bus_oe, addr_oe, tx_valid, halted}, 0);
    check("rst_pulses", {cpu_clk, cpu_iclk}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("cpu_rst_hold", cpu_rst, 1);
    check("rx_ready_rel", rx_ready, 1);
    @(negedge clk);
    check("cpu_rst_drop", cpu_rst, 0);

    send("A"); send(8'h34); send(8'h12);
    @(negedge clk);
    check("addr_out", addr_out, 16'h1234);
    check("addr_oe", addr_oe, 1);
    addr_in = 16'hBEEF;
    send("a");
    recv("a0", 8'hEF);
    recv("a1", 8'hBE);
    check("a_done", tx_valid, 0);

    send("B"); send(8'h5A);
    @(negedge clk);
    check("bus_out", bus_out, 8'h5A);
    check("bus_oe", bus_oe, 1);
    bus_in = 8'hC3;
    send("b"); recv("b0", 8'hC3);
    flags_in = 4'hA;
    send("s"); recv("s0", 8'h0A);
    send("r"); recv("r0", 8'h00);
    send("R");
    recv("R0", "#"); recv("R1", "B"); recv("R2", "R"); recv("R3", "K");

    send("M"); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    @(negedge clk);
    check("cw_M", control_word, 32'h1234_5678);
    send("O"); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
    @(negedge clk);
    check("cw_O", control_word, 32'h0000_0001);
    check("O_oe_clr", {bus_oe, addr_oe}, 0);

    t_clk  = 7'b0000011;
    t_iclk = 7'b0110000;
    t_rdy  = 7'b1000000;
    send("T");
    check("T_pre", {cpu_clk, cpu_iclk}, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("T_clk%0d", i), cpu_clk, t_clk[i]);
      check($sformatf("T_iclk%0d", i), cpu_iclk, t_iclk[i]);
      check($sformatf("T_rdy%0d", i), rx_ready, t_rdy[i]);
    end

    send("c");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("c_clk%0d", i), {cpu_clk, cpu_iclk},
            (i < 2) ? 2'b10 : 2'b00);
    end
    send("C");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("C_iclk%0d", i), {cpu_clk, cpu_iclk},
            (i < 2) ? 2'b01 : 2'b00);
    end

    ident = "VerilogVM";
    prev_hold = 1'b0;
    prev_d = '0;
    send("I");
    for (int k = 0; k < 45; k++) begin
      tx_ready = (k % 3 == 2);
      if (prev_hold) check("I_stable", tx_data, prev_d);
      prev_hold = tx_valid && !tx_ready;
      prev_d = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      @(posedge clk);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("I_len", got.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("I_byte%0d", i), (i < got.size()) ? got[i] : 8'h00,
            ident[i]);

    send("Z");
    @(negedge clk);
    @(negedge clk);
    check("unk_quiet", tx_valid, 0);
    check("unk_ready", rx_ready, 1);

    send("M"); send(8'h11);
    #2 rst = 1'b0;
    #1 check("abort_cw", control_word, DCW);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send("M"); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    @(negedge clk);
    check("cw_after_abort", control_word, 32'h0403_0201);

    send("Q");
    @(negedge clk);
    @(negedge clk);
    check("halted", halted, 1);
    check("halt_rx", rx_ready, 0);
    rx_data = "B";
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_data = 8'h55;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("halt_bus_oe", bus_oe, 0);
    check("halt_stays", halted, 1);
    #2 rst = 1'b0;
    #1 check("halt_clr", halted, 0);
    check("halt_rst_cw", control_word, DCW);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", rx_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
